// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall sequencer: per-stage control
// encodings, sequencer state codes and the packed five-stage control word.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      CTRL_STATE_DEFAULT = 2'b00,
      CTRL_STATE_STALL   = 2'b01,
      CTRL_STATE_FLUSH   = 2'b10
   } ctrl_state_e;

   typedef enum logic [1:0] {
      PIPE_RUN        = 2'b00,
      PIPE_MEM_WAIT   = 2'b01,
      PIPE_TRAP_FLUSH = 2'b10
   } pipe_state_e;

   typedef struct packed {
      ctrl_state_e pc;
      ctrl_state_e if_id;
      ctrl_state_e id_ex;
      ctrl_state_e ex_mem;
      ctrl_state_e mem_wb;
   } ctrl_vec_t;

   // Wait and trap-flush counters share one width; MEM_TIMEOUT tops out at 2^16-1.
   localparam int SAT_W = 16;

   function automatic ctrl_vec_t ctrl_vec(input ctrl_state_e pc, input ctrl_state_e if_id,
                                          input ctrl_state_e id_ex, input ctrl_state_e ex_mem,
                                          input ctrl_state_e mem_wb);
      ctrl_vec_t v;
      v.pc     = pc;
      v.if_id  = if_id;
      v.id_ex  = id_ex;
      v.ex_mem = ex_mem;
      v.mem_wb = mem_wb;
      return v;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the pipeline stages (master) and the
// hazard sequencer (slave).
interface pipe_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
);
   logic             trap_i;
   logic             mem_req_i;
   logic             mem_ack_i;
   logic             branch_taken_i;
   logic             ld_use_i;
   logic             if_stall_i;
   logic             perf_clr_i;
   ctrl_state_e      ctrl_pc_o;
   ctrl_state_e      ctrl_if_id_o;
   ctrl_state_e      ctrl_id_ex_o;
   ctrl_state_e      ctrl_ex_mem_o;
   ctrl_state_e      ctrl_mem_wb_o;
   logic             mem_busy_o;
   logic             mem_timeout_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport master (
      output trap_i, mem_req_i, mem_ack_i, branch_taken_i, ld_use_i, if_stall_i, perf_clr_i,
      input  ctrl_pc_o, ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o,
      input  mem_busy_o, mem_timeout_o, stall_cnt_o
   );

   modport slave (
      input  trap_i, mem_req_i, mem_ack_i, branch_taken_i, ld_use_i, if_stall_i, perf_clr_i,
      output ctrl_pc_o, ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o,
      output mem_busy_o, mem_timeout_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up/down counter with clear and load; holds at MAX going up
// and at zero going down. Priority: clr, load, inc, dec.
module sat_counter #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (inc && (count != MAX)) begin
         count <= count + 1'b1;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall sequencer: arbitrates trap, memory wait, redirect,
// load-use and fetch-wait into per-stage control words, plus perf/timeout.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TRAP_FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT       = 255,
   parameter int CNT_W             = 32
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);

   localparam ctrl_state_e D = CTRL_STATE_DEFAULT;
   localparam ctrl_state_e S = CTRL_STATE_STALL;
   localparam ctrl_state_e F = CTRL_STATE_FLUSH;

   localparam logic [SAT_W-1:0] ONE         = SAT_W'(1);
   localparam logic [SAT_W-1:0] TIMEOUT_VAL = SAT_W'(MEM_TIMEOUT);
   localparam logic [SAT_W-1:0] FLUSH_VAL   = SAT_W'(TRAP_FLUSH_CYCLES);
   localparam logic [SAT_W-1:0] FLUSH_MAX   = (TRAP_FLUSH_CYCLES > 0) ? FLUSH_VAL : ONE;
   localparam bit               HAS_FLUSH   = (TRAP_FLUSH_CYCLES > 0);

   pipe_state_e      state, next_state;
   ctrl_vec_t        ctrl;
   logic             wait_load, wait_inc, wait_clr;
   logic             trap_load, trap_dec;
   logic             timeout_hit;
   logic             mem_timeout;
   logic [SAT_W-1:0] wait_cnt, trap_cnt;
   logic [CNT_W-1:0] stall_cnt;

   sat_counter #(.WIDTH(SAT_W), .MAX(TIMEOUT_VAL)) u_wait_cnt (
      .clk(clk), .rst(rst), .clr(wait_clr), .load(wait_load), .load_val(ONE),
      .inc(wait_inc), .dec(1'b0), .count(wait_cnt)
   );

   sat_counter #(.WIDTH(SAT_W), .MAX(FLUSH_MAX)) u_trap_cnt (
      .clk(clk), .rst(rst), .clr(1'b0), .load(trap_load), .load_val(FLUSH_VAL),
      .inc(1'b0), .dec(trap_dec), .count(trap_cnt)
   );

   // Mealy arbitration; stage registers act on these words at the next edge.
   always_comb begin
      ctrl       = ctrl_vec(D, D, D, D, D);
      next_state = state;
      wait_load  = 1'b0;
      wait_inc   = 1'b0;
      wait_clr   = 1'b0;
      trap_load  = 1'b0;
      trap_dec   = 1'b0;
      case (state)
         PIPE_RUN: begin
            if (bus.trap_i) begin
               ctrl = ctrl_vec(D, F, F, F, F);
               if (HAS_FLUSH) begin
                  next_state = PIPE_TRAP_FLUSH;
                  trap_load  = 1'b1;
               end
            end else if (bus.mem_req_i && !bus.mem_ack_i) begin
               ctrl       = ctrl_vec(S, S, S, S, F);
               next_state = PIPE_MEM_WAIT;
               wait_load  = 1'b1;
            end else if (bus.branch_taken_i) begin
               ctrl = ctrl_vec(D, F, F, D, D);
            end else if (bus.ld_use_i) begin
               ctrl = ctrl_vec(S, S, F, D, D);
            end else if (bus.if_stall_i) begin
               ctrl = ctrl_vec(S, F, D, D, D);
            end
         end
         PIPE_MEM_WAIT: begin
            // Upstream requests are frozen here and get re-evaluated after the ack.
            if (bus.mem_ack_i) begin
               next_state = PIPE_RUN;
               wait_clr   = 1'b1;
            end else begin
               ctrl     = ctrl_vec(S, S, S, S, F);
               wait_inc = 1'b1;
            end
         end
         PIPE_TRAP_FLUSH: begin
            ctrl     = ctrl_vec(S, F, F, F, D);
            trap_dec = 1'b1;
            if (trap_cnt <= ONE) begin
               next_state = PIPE_RUN;
            end
         end
         default: begin
            next_state = PIPE_RUN;
         end
      endcase
      if (!rst) begin
         ctrl = ctrl_vec(D, D, D, D, D);
      end
   end

   // Fires only on the transition into MEM_TIMEOUT, so saturation does not re-pulse.
   assign timeout_hit = (wait_load && (TIMEOUT_VAL == ONE)) ||
                        (wait_inc && (wait_cnt == TIMEOUT_VAL - ONE));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= PIPE_RUN;
         mem_timeout <= 1'b0;
      end else begin
         state       <= next_state;
         mem_timeout <= timeout_hit;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (bus.perf_clr_i) begin
         stall_cnt <= '0;
      end else if (ctrl.pc == S) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign bus.ctrl_pc_o     = ctrl.pc;
   assign bus.ctrl_if_id_o  = ctrl.if_id;
   assign bus.ctrl_id_ex_o  = ctrl.id_ex;
   assign bus.ctrl_ex_mem_o = ctrl.ex_mem;
   assign bus.ctrl_mem_wb_o = ctrl.mem_wb;
   assign bus.mem_busy_o    = (state == PIPE_MEM_WAIT);
   assign bus.mem_timeout_o = mem_timeout;
   assign bus.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed rows push the expected per-cycle
// response, and a negedge monitor pops and compares it against the DUT.
module tb_pipe_ctrl
   import pipe_ctrl_pkg::*;
;

   localparam ctrl_state_e D = CTRL_STATE_DEFAULT;
   localparam ctrl_state_e S = CTRL_STATE_STALL;
   localparam ctrl_state_e F = CTRL_STATE_FLUSH;

   localparam ctrl_vec_t V_D    = ctrl_vec(D, D, D, D, D);
   localparam ctrl_vec_t V_MEMS = ctrl_vec(S, S, S, S, F);
   localparam ctrl_vec_t V_BR   = ctrl_vec(D, F, F, D, D);
   localparam ctrl_vec_t V_LDU  = ctrl_vec(S, S, F, D, D);
   localparam ctrl_vec_t V_IFS  = ctrl_vec(S, F, D, D, D);
   localparam ctrl_vec_t V_TRAP = ctrl_vec(D, F, F, F, F);
   localparam ctrl_vec_t V_TF   = ctrl_vec(S, F, F, F, D);

   // Input bits: {rst, trap, mem_req, mem_ack, branch, ld_use, if_stall, perf_clr}
   localparam logic [7:0] R    = 8'h80;
   localparam logic [7:0] TRAP = 8'h40;
   localparam logic [7:0] MREQ = 8'h20;
   localparam logic [7:0] MACK = 8'h10;
   localparam logic [7:0] BR   = 8'h08;
   localparam logic [7:0] LDU  = 8'h04;
   localparam logic [7:0] IFS  = 8'h02;
   localparam logic [7:0] PCLR = 8'h01;

   typedef struct {
      int          row;
      logic [15:0] val;
   } exp_t;

   logic clk;
   logic rst;
   exp_t exp_q[$];
   int   row_idx;
   int   checks;
   int   failures;

   pipe_ctrl_if #(.CNT_W(4)) bus ();

   pipe_ctrl #(
      .TRAP_FLUSH_CYCLES(2),
      .MEM_TIMEOUT(4),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [7:0] in_bits, input ctrl_vec_t exp_ctrl,
                                input logic exp_busy, input logic exp_to, input logic [3:0] exp_cnt);
      exp_t e;
      @(posedge clk);
      #1;
      {rst, bus.trap_i, bus.mem_req_i, bus.mem_ack_i, bus.branch_taken_i,
       bus.ld_use_i, bus.if_stall_i, bus.perf_clr_i} = in_bits;
      e.row = row_idx;
      e.val = {exp_ctrl, exp_busy, exp_to, exp_cnt};
      exp_q.push_back(e);
      row_idx++;
   endtask

   task automatic checkOutput(input int row, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL row %0d: got ctrl=%b busy=%b timeout=%b cnt=%0d, expected ctrl=%b busy=%b timeout=%b cnt=%0d",
                  row, actual[15:6], actual[5], actual[4], actual[3:0],
                  expected[15:6], expected[5], expected[4], expected[3:0]);
      end
   endtask

   // Monitor: one expected entry per stimulus cycle, compared mid-cycle.
   initial begin
      exp_t e;
      logic [15:0] obs;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = {bus.ctrl_pc_o, bus.ctrl_if_id_o, bus.ctrl_id_ex_o, bus.ctrl_ex_mem_o,
                   bus.ctrl_mem_wb_o, bus.mem_busy_o, bus.mem_timeout_o, bus.stall_cnt_o};
            checkOutput(e.row, obs, e.val);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached, expected bench completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks   = 0;
      failures = 0;
      row_idx  = 0;
      rst = 1'b0;
      {bus.trap_i, bus.mem_req_i, bus.mem_ack_i, bus.branch_taken_i,
       bus.ld_use_i, bus.if_stall_i, bus.perf_clr_i} = '0;
      $display("[TB] start");

      // Reset holds all-D even with requests present; then idle.
      applyStimulus(TRAP | MREQ | BR, V_D, 1'b0, 1'b0, 4'd0);
      applyStimulus(R, V_D, 1'b0, 1'b0, 4'd0);
      applyStimulus(R, V_D, 1'b0, 1'b0, 4'd0);
      // Memory wait: three stall cycles, then ack.
      applyStimulus(R | MREQ, V_MEMS, 1'b0, 1'b0, 4'd0);
      applyStimulus(R | MREQ, V_MEMS, 1'b1, 1'b0, 4'd1);
      applyStimulus(R | MREQ, V_MEMS, 1'b1, 1'b0, 4'd2);
      applyStimulus(R | MREQ | MACK, V_D, 1'b1, 1'b0, 4'd3);
      applyStimulus(R, V_D, 1'b0, 1'b0, 4'd3);
      // Priority among redirect, load-use and fetch-wait.
      applyStimulus(R | BR | LDU | IFS, V_BR, 1'b0, 1'b0, 4'd3);
      applyStimulus(R | LDU, V_LDU, 1'b0, 1'b0, 4'd3);
      applyStimulus(R | IFS, V_IFS, 1'b0, 1'b0, 4'd4);
      applyStimulus(R | MREQ | MACK | LDU, V_LDU, 1'b0, 1'b0, 4'd5);
      // Trap beats everything, then two flush cycles ignoring requests.
      applyStimulus(R | TRAP | BR | LDU | MREQ, V_TRAP, 1'b0, 1'b0, 4'd6);
      applyStimulus(R | MREQ | BR, V_TF, 1'b0, 1'b0, 4'd6);
      applyStimulus(R | MREQ | BR | TRAP, V_TF, 1'b0, 1'b0, 4'd7);
      applyStimulus(R, V_D, 1'b0, 1'b0, 4'd8);
      // Timeout on the 4th MEM_WAIT cycle, stall counter wraps, then clear.
      applyStimulus(R | MREQ, V_MEMS, 1'b0, 1'b0, 4'd8);
      applyStimulus(R | MREQ | TRAP, V_MEMS, 1'b1, 1'b0, 4'd9);
      applyStimulus(R | MREQ | BR, V_MEMS, 1'b1, 1'b0, 4'd10);
      applyStimulus(R | MREQ, V_MEMS, 1'b1, 1'b0, 4'd11);
      applyStimulus(R | MREQ, V_MEMS, 1'b1, 1'b1, 4'd12);
      applyStimulus(R | MREQ, V_MEMS, 1'b1, 1'b0, 4'd13);
      applyStimulus(R | MREQ, V_MEMS, 1'b1, 1'b0, 4'd14);
      applyStimulus(R | MREQ, V_MEMS, 1'b1, 1'b0, 4'd15);
      applyStimulus(R | MREQ, V_MEMS, 1'b1, 1'b0, 4'd0);
      applyStimulus(R | MREQ | PCLR, V_MEMS, 1'b1, 1'b0, 4'd1);
      applyStimulus(R | MREQ | MACK, V_D, 1'b1, 1'b0, 4'd0);
      applyStimulus(R, V_D, 1'b0, 1'b0, 4'd0);
      // Asynchronous reset in the middle of MEM_WAIT.
      applyStimulus(R | MREQ, V_MEMS, 1'b0, 1'b0, 4'd0);
      applyStimulus(R | MREQ, V_MEMS, 1'b1, 1'b0, 4'd1);
      applyStimulus(MREQ, V_D, 1'b0, 1'b0, 4'd0);
      applyStimulus(R, V_D, 1'b0, 1'b0, 4'd0);
      applyStimulus(R | LDU, V_LDU, 1'b0, 1'b0, 4'd0);

      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central hazard/stall sequencer for the 5-stage pipeline. Drives the per-stage control word (`CTRL_Wire_Bus`) consumed by PC, IF_ID, ID_EX, EX_MEM and MEM_WB. Arbitrates trap, memory-wait, branch-redirect, load-use and fetch-wait requests by fixed priority. Also keeps a stall-cycle performance counter and a memory-wait timeout.

Parameters:
TRAP_FLUSH_CYCLES, 2, extra cycles the front end stays flushed after a trap (CSR settle); 0 means no extra cycles.
MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout_o pulses; range 1..2^16-1.
CNT_W, 32, stall counter width.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-low reset
trap_i  in  1  MEM-stage exception/mret; PC loads trap vector this cycle
mem_req_i  in  1  MEM stage holds a load/store
mem_ack_i  in  1  data bus completes the transaction this cycle
branch_taken_i  in  1  EX-stage redirect
ld_use_i  in  1  ID-stage load-use hazard
if_stall_i  in  1  instruction fetch not ready
perf_clr_i  in  1  synchronous clear of stall_cnt_o
ctrl_pc_o  out  `CTRL_Wire_Bus`  PC control
ctrl_if_id_o  out  `CTRL_Wire_Bus`  IF_ID control
ctrl_id_ex_o  out  `CTRL_Wire_Bus`  ID_EX control
ctrl_ex_mem_o  out  `CTRL_Wire_Bus`  EX_MEM control
ctrl_mem_wb_o  out  `CTRL_Wire_Bus`  MEM_WB control
mem_busy_o  out  1  high while in MEM_WAIT
mem_timeout_o  out  1  one-cycle pulse on timeout
stall_cnt_o  out  CNT_W  count of cycles where ctrl_pc_o == Stall

Behaviour:
- Encodings: D = `CTRL_STATE_Default`, S = `CTRL_STATE_Stall`, F = `CTRL_STATE_Flush`.
- Ctrl outputs are combinational from state and inputs (Mealy). Stage registers act on the next edge.
- While rst is low:
  - state = RUN; counters = 0; mem_timeout_o = 0.
  - All ctrl outputs = D; mem_busy_o = 0; stall_cnt_o = 0.
- Output order below is PC, IF_ID, ID_EX, EX_MEM, MEM_WB.
- States are RUN, MEM_WAIT and TRAP_FLUSH.
- RUN uses this priority, first match wins:
  1. trap_i: outputs D,F,F,F,F. Go to TRAP_FLUSH if TRAP_FLUSH_CYCLES>0 (load counter = TRAP_FLUSH_CYCLES), else stay in RUN.
  2. mem_req_i & !mem_ack_i: outputs S,S,S,S,F. Go to MEM_WAIT; wait counter = 1.
  3. branch_taken_i: outputs D,F,F,D,D.
  4. ld_use_i: outputs S,S,F,D,D.
  5. if_stall_i: outputs S,F,D,D,D.
  6. Otherwise: all D.
- mem_req_i & mem_ack_i in the same RUN cycle means no stall; fall through to rules 3-6.
- MEM_WAIT:
  - !mem_ack_i: outputs S,S,S,S,F; wait counter increments, saturating at MEM_TIMEOUT.
  - mem_timeout_o pulses for exactly one cycle, on the cycle the counter first reaches MEM_TIMEOUT. The block stays in MEM_WAIT afterwards.
  - mem_ack_i: all outputs D; return to RUN; wait counter cleared.
  - trap_i, branch_taken_i, ld_use_i and if_stall_i are ignored here. Their source stages are frozen and re-evaluate after the ack.
- TRAP_FLUSH:
  - Outputs S,F,F,F,D; counter decrements each cycle.
  - On the cycle the counter reaches 1, return to RUN.
  - All request inputs are ignored.
- stall_cnt_o:
  - Increments each cycle ctrl_pc_o == S; wraps from 2^CNT_W-1 to 0.
  - perf_clr_i forces 0 on the next edge and takes priority over increment.
- Asynchronous reset mid-MEM_WAIT or mid-TRAP_FLUSH aborts to RUN immediately. Outputs go to all-D while rst is low.
- mem_busy_o = (state == MEM_WAIT).

Decomposition:
- `defines.v` gains:
  - `CTRL_STATE_Stall` and `CTRL_STATE_Flush` beside `CTRL_STATE_Default`.
  - FSM state codes `PIPE_RUN`, `PIPE_MEM_WAIT`, `PIPE_TRAP_FLUSH` (2 bits).
- All flops are built from the existing `Reg` primitive, with its reset converted to asynchronous active-low.
- One sub-module: `sat_counter` (width param, inc/clr/load, saturating). Instantiated for the wait counter and the trap-flush counter.
- stall_cnt_o is a plain wrapping register.

Test Plan:
- Reset then idle with all inputs 0 -> all ctrl outputs D, stall_cnt_o = 0, mem_busy_o = 0.
- mem_req_i=1 held with mem_ack_i=0 for 3 cycles, then ack -> 3 cycles of S,S,S,S,F with mem_busy_o=1; ack cycle all D; stall_cnt_o = 3.
- MEM_TIMEOUT=4, mem_ack_i never asserted -> mem_timeout_o high exactly one cycle, on the 4th MEM_WAIT cycle; still in MEM_WAIT.
- trap_i, branch_taken_i and ld_use_i asserted together in RUN, TRAP_FLUSH_CYCLES=2 -> D,F,F,F,F; then 2 cycles of S,F,F,F,D; then RUN.
- branch_taken_i with ld_use_i and if_stall_i -> D,F,F,D,D. Then ld_use_i alone -> S,S,F,D,D. Then if_stall_i alone -> S,F,D,D,D.
- CNT_W=4, stall counter preset by 15 stall cycles, one more stall -> stall_cnt_o wraps to 0. Separately, perf_clr_i during a stall cycle -> 0.
